// File: rtl/and16_bist_driver.sv
// Self-test driver for a 16-bit bitwise AND unit: applies fixed and LFSR operand pairs,
// checks the returned out bus against a&b, and reports pass, an error count and the first failing index.
module and16_bist_driver #(
  parameter int          NUM_RAND = 8,
  parameter int          SETTLE   = 1,
  parameter logic [15:0] SEED_A   = 16'hACE1,
  parameter logic [15:0] SEED_B   = 16'h1D87
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [15:0] vec_a,
  output logic [15:0] vec_b,
  input  logic [15:0] dut_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [15:0] fail_idx
);

  localparam int          T    = 4 + NUM_RAND;
  localparam logic [15:0] SA   = (SEED_A == 16'h0000) ? 16'h0001 : SEED_A;
  localparam logic [15:0] SB   = (SEED_B == 16'h0000) ? 16'h0001 : SEED_B;
  localparam logic [15:0] POLY = 16'hB400;

  typedef enum logic [2:0] {IDLE, LOAD, SETTLING, CHECK, DONE_S} state_t;

  state_t      state_reg, state_next;
  logic [31:0] idx_reg, idx_next;
  logic [31:0] cnt_reg, cnt_next;
  logic [15:0] lfsr_a_reg, lfsr_a_next;
  logic [15:0] lfsr_b_reg, lfsr_b_next;
  logic [15:0] vec_a_reg, vec_a_next;
  logic [15:0] vec_b_reg, vec_b_next;
  logic [15:0] err_reg, err_next;
  logic [15:0] fidx_reg, fidx_next;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? POLY : 16'h0000);
  endfunction

  function automatic logic [15:0] fixed_a(input logic [1:0] i);
    case (i)
      2'd2:    return 16'hA211;
      2'd3:    return 16'h0001;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] fixed_b(input logic [1:0] i);
    case (i)
      2'd1:    return 16'h0001;
      2'd2:    return 16'h0730;
      2'd3:    return 16'h0003;
      default: return 16'h0000;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      cnt_reg    <= '0;
      lfsr_a_reg <= SA;
      lfsr_b_reg <= SB;
      vec_a_reg  <= '0;
      vec_b_reg  <= '0;
      err_reg    <= '0;
      fidx_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      cnt_reg    <= cnt_next;
      lfsr_a_reg <= lfsr_a_next;
      lfsr_b_reg <= lfsr_b_next;
      vec_a_reg  <= vec_a_next;
      vec_b_reg  <= vec_b_next;
      err_reg    <= err_next;
      fidx_reg   <= fidx_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    cnt_next    = cnt_reg;
    lfsr_a_next = lfsr_a_reg;
    lfsr_b_next = lfsr_b_reg;
    vec_a_next  = vec_a_reg;
    vec_b_next  = vec_b_reg;
    err_next    = err_reg;
    fidx_next   = fidx_reg;
    case (state_reg)
      IDLE, DONE_S: begin
        if (start) begin
          state_next  = LOAD;
          idx_next    = '0;
          lfsr_a_next = SA;
          lfsr_b_next = SB;
          err_next    = '0;
          fidx_next   = '0;
          vec_a_next  = fixed_a(2'd0);
          vec_b_next  = fixed_b(2'd0);
        end
      end
      LOAD: begin
        state_next = SETTLING;
        cnt_next   = '0;
      end
      SETTLING: begin
        if (cnt_reg == 32'(SETTLE - 1)) state_next = CHECK;
        else                            cnt_next   = cnt_reg + 32'd1;
      end
      CHECK: begin
        if (dut_out != (vec_a_reg & vec_b_reg)) begin
          if (err_reg != 16'hFFFF) err_next  = err_reg + 16'd1;
          if (err_reg == 16'h0000) fidx_next = idx_reg[15:0];
        end
        if (idx_reg == 32'(T - 1)) begin
          state_next = DONE_S;
        end else begin
          state_next = LOAD;
          idx_next   = idx_reg + 32'd1;
          // The random pair for index 4 is the seed itself; step only after it has been used.
          if (idx_reg >= 32'd4) begin
            lfsr_a_next = lfsr_step(lfsr_a_reg);
            lfsr_b_next = lfsr_step(lfsr_b_reg);
          end
          if (idx_next >= 32'd4) begin
            vec_a_next = lfsr_a_next;
            vec_b_next = lfsr_b_next;
          end else begin
            vec_a_next = fixed_a(idx_next[1:0]);
            vec_b_next = fixed_b(idx_next[1:0]);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign vec_a     = vec_a_reg;
  assign vec_b     = vec_b_reg;
  assign busy      = (state_reg == LOAD) || (state_reg == SETTLING) || (state_reg == CHECK);
  assign done      = (state_reg == DONE_S);
  assign pass      = (state_reg == DONE_S) && (err_reg == 16'h0000);
  assign err_count = err_reg;
  assign fail_idx  = fidx_reg;

endmodule
